md5_stream_padder: RTL and testbench

- Parametrised front end for the md5 core.
- Accepts an arbitrary-length byte message as a stream of IN_BYTES-wide beats.
- Emits MD5-padded 512-bit blocks, each with first/last flags, so the core can hash multi-block messages rather than one pre-padded part.
- Handles the 0x80 terminator, zero fill, the 64-bit little-endian bit-length field, and the spill into an extra block.

---
 rtl/md5_stream_padder.sv | 95 +++++++++
 tb/tb_md5_stream_padder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/md5_stream_padder.sv
// md5_stream_padder: packs a byte stream into MD5-padded 512-bit blocks with first/last flags
module md5_stream_padder #(
  parameter int IN_BYTES = 4,
  parameter int LEN_W = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [8*IN_BYTES-1:0]        in_data,
  input  logic [$clog2(IN_BYTES+1)-1:0] in_nbytes,
  input  logic                         in_last,
  output logic                         blk_valid,
  input  logic                         blk_ready,
  output logic [511:0]                 blk_data,
  output logic                         blk_first,
  output logic                         blk_last
);
  typedef enum logic [2:0] {ACCEPT, OUT_DATA, OUT_SPILL, OUT_FULL, OUT_FINAL} state_t;
  state_t state, state_n;
  logic [511:0] blk_q, blk_n, sh;
  logic [6:0] ptr, ptr_n, p;
  logic [LEN_W-1:0] cnt, cnt_n, cnt_add;
  logic first_q, first_n;
  logic [63:0] len;
  assign p = ptr + 7'(in_nbytes);
  assign cnt_add = cnt + LEN_W'({in_nbytes, 3'b000});
  assign sh = 512'(in_data) << {ptr, 3'b000};
  assign len = 64'(cnt);
  assign in_ready = state == ACCEPT && !reset;
  assign blk_valid = state != ACCEPT;
  assign blk_first = blk_valid && first_q;
  assign blk_last = state == OUT_FINAL;
  assign blk_data = blk_q;
  always_comb begin
    state_n = state;
    blk_n = blk_q;
    ptr_n = ptr;
    cnt_n = cnt;
    first_n = first_q;
    case (state)
      ACCEPT: if (in_valid) begin
        ptr_n = p;
        cnt_n = cnt_add;
        for (int j = 0; j < 64; j++) begin
          if (7'(j) >= ptr && 7'(j) < p) blk_n[8*j +: 8] = sh[8*j +: 8];
          else if (in_last && 7'(j) == p) blk_n[8*j +: 8] = 8'h80;
        end
        if (in_last && p <= 7'd55) blk_n[511:448] = 64'(cnt_add);
        state_n = in_last ? (p <= 7'd55 ? OUT_FINAL : p == 7'd64 ? OUT_FULL : OUT_SPILL)
                          : (p == 7'd64 ? OUT_DATA : ACCEPT);
      end
      default: if (blk_ready) begin
        first_n = 1'b0;
        case (state)
          OUT_DATA: begin
            blk_n = '0;
            ptr_n = '0;
            state_n = ACCEPT;
          end
          OUT_SPILL: begin
            blk_n = {len, 448'h0};
            state_n = OUT_FINAL;
          end
          OUT_FULL: begin
            blk_n = {len, 440'h0, 8'h80};
            state_n = OUT_FINAL;
          end
          default: begin
            blk_n = '0;
            ptr_n = '0;
            cnt_n = '0;
            first_n = 1'b1;
            state_n = ACCEPT;
          end
        endcase
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCEPT;
      blk_q <= '0;
      ptr <= '0;
      cnt <= '0;
      first_q <= 1'b1;
    end else begin
      state <= state_n;
      blk_q <= blk_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      first_q <= first_n;
    end
  end
endmodule

// File: tb/tb_md5_stream_padder.sv
// tb_md5_stream_padder: randomized stream bench against a byte-level padding model
module tb_md5_stream_padder;
  logic clk = 0, reset = 1, in_valid = 0, in_last = 0, blk_ready = 0;
  logic [31:0] in_data = 0;
  logic [2:0] in_nbytes = 0;
  logic blk_valid, in_ready, blk_first, blk_last;
  logic [511:0] blk_data;
  typedef struct {logic [511:0] d; bit f; bit l;} blk_t;
  blk_t exp_q[$];
  logic [511:0] got_d[$];
  bit got_f[$], got_l[$];
  logic [7:0] msg[$];
  int asserts = 0, fails = 0, idx;
  bit hold = 1, rnd = 0, gaps = 0;
  always #5 clk = ~clk;
  md5_stream_padder dut (.clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_nbytes(in_nbytes), .in_last(in_last), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last));
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
    asserts++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask
  function automatic void add_msg();
    logic [7:0] q[$];
    longint len;
    blk_t e;
    q = msg;
    len = longint'(msg.size()) * 8;
    q.push_back(8'h80);
    while (q.size() % 64 != 56) q.push_back(8'h00);
    for (int i = 0; i < 8; i++) q.push_back(8'(len >> (8 * i)));
    for (int b = 0; b < q.size() / 64; b++) begin
      for (int k = 0; k < 64; k++) e.d[8*k +: 8] = q[64*b + k];
      e.f = b == 0;
      e.l = b == q.size() / 64 - 1;
      exp_q.push_back(e);
    end
  endfunction
  task automatic send_msg(input bit lastflag);
    int n, i, nb, t;
    bit done;
    logic [31:0] d;
    n = msg.size();
    i = 0;
    done = 0;
    while (!done) begin
      nb = (n - i) > 4 ? 4 : (n - i);
      d = $urandom;
      for (int k = 0; k < nb; k++) d[8*k +: 8] = msg[i + k];
      if (gaps && $urandom % 4 == 0) begin
        in_valid = 0;
        @(posedge clk); #1;
      end
      in_valid = 1;
      in_data = d;
      in_nbytes = 3'(nb);
      in_last = lastflag && (i + nb >= n);
      t = 0;
      while (1) begin
        @(negedge clk);
        if (in_ready) break;
        if (++t > 500) begin
          asserts++;
          fails++;
          $display("FAIL accept_timeout: in_ready got 0 required 1");
          break;
        end
      end
      @(posedge clk); #1;
      i += nb;
      done = (i >= n) || t > 500;
    end
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || blk_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      asserts++;
      fails++;
      $display("FAIL drain_timeout: pending blocks got %0d required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask
  initial forever begin
    @(posedge clk); #1;
    blk_ready = hold ? 1'b0 : rnd ? ($urandom % 3 != 0) : 1'b1;
  end
  initial begin
    bit pv, pr, pf, pl;
    logic [511:0] pd;
    blk_t e;
    pv = 0; pr = 0; pf = 0; pl = 0; pd = '0;
    forever begin
      @(negedge clk);
      if (reset) pv = 0;
      else begin
        if (blk_valid) begin
          chk("in_ready_during_output", in_ready, 0);
          if (pv && !pr) begin
            chk("hold_data", blk_data, pd);
            chk("hold_first", blk_first, pf);
            chk("hold_last", blk_last, pl);
          end
          if (blk_ready) begin
            if (exp_q.size() == 0) begin
              asserts++;
              fails++;
              $display("FAIL unexpected_block: got %h required none", blk_data);
            end else begin
              e = exp_q.pop_front();
              chk("blk_data", blk_data, e.d);
              chk("blk_first", blk_first, e.f);
              chk("blk_last", blk_last, e.l);
            end
            got_d.push_back(blk_data);
            got_f.push_back(blk_first);
            got_l.push_back(blk_last);
          end
        end
        pv = blk_valid; pr = blk_ready; pd = blk_data; pf = blk_first; pl = blk_last;
      end
    end
  end
  initial begin
    logic [511:0] hd;
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_blk_valid", blk_valid, 0);
    chk("reset_blk_data", blk_data, 0);
    chk("reset_blk_first", blk_first, 0);
    chk("reset_blk_last", blk_last, 0);
    chk("reset_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 0;
    hold = 0;
    @(negedge clk);
    chk("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;
    idx = got_d.size();
    msg = '{8'h61, 8'h62, 8'h63};
    add_msg();
    send_msg(1);
    drain();
    chk("abc_block", got_d[idx], {56'h0, 8'h18, 416'h0, 32'h80636261});
    chk("abc_first", got_f[idx], 1);
    chk("abc_last", got_l[idx], 1);
    idx = got_d.size();
    msg = {};
    add_msg();
    send_msg(1);
    drain();
    chk("empty_block", got_d[idx], {504'h0, 8'h80});
    chk("empty_flags", {got_f[idx], got_l[idx]}, 2'b11);
    idx = got_d.size();
    msg = {};
    for (int i = 0; i < 56; i++) msg.push_back(8'h41);
    add_msg();
    send_msg(1);
    drain();
    chk("m56_block1", got_d[idx], {56'h0, 8'h80, {56{8'h41}}});
    chk("m56_flags1", {got_f[idx], got_l[idx]}, 2'b10);
    chk("m56_block2", got_d[idx+1], {48'h0, 8'h01, 8'hC0, 448'h0});
    chk("m56_flags2", {got_f[idx+1], got_l[idx+1]}, 2'b01);
    idx = got_d.size();
    msg = {};
    for (int i = 0; i < 64; i++) msg.push_back(8'(i * 7 + 1));
    add_msg();
    send_msg(1);
    drain();
    chk("m64_last1", got_l[idx], 0);
    chk("m64_block2", got_d[idx+1], {48'h0, 8'h02, 8'h00, 440'h0, 8'h80});
    chk("m64_last2", got_l[idx+1], 1);
    msg = {};
    for (int i = 0; i < 68; i++) msg.push_back(8'($urandom));
    add_msg();
    hold = 1;
    fork
      send_msg(1);
      begin
        t = 0;
        while (!blk_valid && t < 500) begin
          @(negedge clk);
          t++;
        end
        hd = blk_data;
        repeat (10) begin
          chk("bp_in_ready", in_ready, 0);
          chk("bp_valid", blk_valid, 1);
          @(negedge clk);
        end
        chk("bp_stable", blk_data, hd);
        hold = 0;
      end
    join
    drain();
    rnd = 1;
    gaps = 1;
    repeat (12) begin
      msg = {};
      for (int i = $urandom_range(0, 140); i > 0; i--) msg.push_back(8'($urandom));
      add_msg();
      send_msg(1);
    end
    drain();
    rnd = 0;
    gaps = 0;
    msg = {};
    for (int i = 0; i < 20; i++) msg.push_back(8'($urandom));
    send_msg(0);
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    exp_q = {};
    idx = got_d.size();
    msg = '{8'h61, 8'h62, 8'h63};
    add_msg();
    send_msg(1);
    drain();
    chk("post_reset_count", got_d.size() - idx, 1);
    chk("post_reset_abc", got_d[idx], {56'h0, 8'h18, 416'h0, 32'h80636261});
    chk("post_reset_flags", {got_f[idx], got_l[idx]}, 2'b11);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
